// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, selects the next PC from branch/jump feedback and
// reads the instruction RAM one cycle ahead so instr always matches pc.
module instr_fetch #(
  parameter int unsigned ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic              jal,
  input  logic              jalr,
  input  logic [31:0]       imm32,
  input  logic [31:0]       alu_result,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              trap
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PROG = 2'd2,
    TRAP = 2'd3
  } state_t;

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        trap_q, trap_d;

  logic [31:0]       seq_pc;
  logic [31:0]       branch_pc;
  logic [31:0]       jalr_pc;
  logic [31:0]       target_pc;
  logic [31:0]       fetch_addr;
  logic [ADDR_W-1:0] fetch_idx;
  logic              unused_bits;

  assign seq_pc    = pc_q + 32'd4;
  assign branch_pc = pc_q + imm32;
  assign jalr_pc   = {alu_result[31:1], 1'b0};
  assign fetch_idx = fetch_addr[ADDR_W+1:2];

  // Upper PC bits and the JALR low bit never reach the RAM index.
  assign unused_bits = ^{fetch_addr, alu_result[0]};

  // Redirect target chosen by the datapath; JALR outranks JAL/branch.
  always_comb begin
    target_pc = seq_pc;
    if (jalr) begin
      target_pc = jalr_pc;
    end else if (jal || br_taken) begin
      target_pc = branch_pc;
    end
  end

  // Next state and fetch address; programming outranks trap, trap outranks stall.
  always_comb begin
    state_d    = state_q;
    fetch_addr = pc_q;
    if (prog_en) begin
      state_d    = PROG;
      fetch_addr = RESET_PC;
    end else begin
      case (state_q)
        BOOT: begin
          state_d    = RUN;
          fetch_addr = RESET_PC;
        end
        RUN: begin
          if (instr_valid_q && !stall) begin
            if (target_pc[1]) begin
              state_d    = TRAP;
              fetch_addr = pc_q;
            end else begin
              fetch_addr = target_pc;
            end
          end
        end
        PROG: begin
          state_d    = BOOT;
          fetch_addr = RESET_PC;
        end
        TRAP: begin
          fetch_addr = pc_q;
        end
      endcase
    end
    pc_d          = fetch_addr;
    instr_valid_d = (state_d == RUN);
    trap_d        = (state_d == TRAP);
  end

  // Read-ahead: the word at the next PC lands in instr together with pc.
  always_comb begin
    instr_d = mem[fetch_idx];
  end

  // Programming port writes; array contents survive reset.
  always_ff @(posedge clk) begin
    if (prog_en && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      trap_q        <= trap_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign trap        = trap_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized and directed bench for instr_fetch with a small
// RAM so address wrap is reachable.
module tb_instr_fetch;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DEPTH    = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic              br_taken = 1'b0;
  logic              jal = 1'b0;
  logic              jalr = 1'b0;
  logic [31:0]       imm32 = 32'd0;
  logic [31:0]       alu_result = 32'd0;
  logic              prog_en = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [31:0]       prog_data = 32'd0;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              trap;

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .jal         (jal),
    .jalr        (jalr),
    .imm32       (imm32),
    .alu_result  (alu_result),
    .prog_en     (prog_en),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .trap        (trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit          trapped;
    bit          chk_pc;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference view of the fetch stage: memory contents, current PC and mode flags.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_prog;
  bit          m_trapped;

  logic [31:0] w0, w1, w2, wa, wb;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_boot    = 1'b1;
    m_prog    = 1'b0;
    m_trapped = 1'b0;
    m_pc      = RESET_PC;
  endtask

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic applyStimulus(input bit st, input bit br, input bit j, input bit jr,
                               input logic [31:0] imm, input logic [31:0] alu,
                               input bit pen, input bit pwe,
                               input logic [ADDR_W-1:0] paddr, input logic [31:0] pdata);
    exp_t        e;
    logic [31:0] target;
    @(negedge clk);
    stall      = st;
    br_taken   = br;
    jal        = j;
    jalr       = jr;
    imm32      = imm;
    alu_result = alu;
    prog_en    = pen;
    prog_we    = pwe;
    prog_addr  = paddr;
    prog_data  = pdata;
    if (pen) begin
      if (pwe) m_mem[int'(paddr)] = pdata;
      m_prog    = 1'b1;
      m_boot    = 1'b0;
      m_trapped = 1'b0;
    end else if (m_prog) begin
      m_prog = 1'b0;
      m_boot = 1'b1;
      m_pc   = RESET_PC;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pc   = RESET_PC;
    end else if (!m_trapped && !st) begin
      if (jr)           target = alu & 32'hFFFF_FFFE;
      else if (j || br) target = m_pc + imm;
      else              target = m_pc + 32'd4;
      if (target[1]) m_trapped = 1'b1;
      else           m_pc = target;
    end
    e.valid   = !(m_prog || m_boot || m_trapped);
    e.trapped = m_trapped;
    e.chk_pc  = e.valid || m_trapped;
    e.pc      = m_pc;
    e.instr   = m_mem[int'((m_pc >> 2) % DEPTH)];
    exp_q.push_back(e);
  endtask

  task automatic step();
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 0, 0, '0, 32'd0);
  endtask

  task automatic progWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1, 1, a, d);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    settle();
    rst_n      = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    jal        = 1'b0;
    jalr       = 1'b0;
    prog_en    = 1'b0;
    prog_we    = 1'b0;
    #1;
    checkOutput("reset_pc_async", pc, RESET_PC);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_pc", pc, RESET_PC);
    checkOutput("reset_instr", instr, 32'd0);
    checkOutput("reset_valid", 32'(instr_valid), 32'd0);
    checkOutput("reset_trap", 32'(trap), 32'd0);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Compare each DUT response against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("instr_valid", 32'(instr_valid), 32'(e.valid));
        checkOutput("trap", 32'(trap), 32'(e.trapped));
        if (e.chk_pc) checkOutput("pc", pc, e.pc);
        if (e.valid) begin
          checkOutput("instr", instr, e.instr);
          checkOutput("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, got %0d checks, expected completion", n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'd0;

    // Load the whole RAM, then reset with preserved contents.
    doReset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == 0)      progWrite(ADDR_W'(i), 32'h0050_0093);
      else if (i == 1) progWrite(ADDR_W'(i), 32'h00A0_0113);
      else             progWrite(ADDR_W'(i), $urandom);
    end
    step();
    doReset();
    step();
    settle();
    checkOutput("first_valid", 32'(instr_valid), 32'd1);
    checkOutput("first_pc", pc, 32'h0);
    checkOutput("first_instr", instr, 32'h0050_0093);
    step();
    settle();
    checkOutput("second_pc", pc, 32'h4);
    checkOutput("second_instr", instr, 32'h00A0_0113);
    checkOutput("second_pc_plus4", pc_plus4, 32'h8);

    // Reprogram three words and restart from RESET_PC.
    w0 = $urandom;
    w1 = $urandom;
    w2 = $urandom;
    progWrite(4'd0, w0);
    progWrite(4'd1, w1);
    progWrite(4'd2, w2);
    step();
    settle();
    checkOutput("boot_gap_valid", 32'(instr_valid), 32'd0);
    step();
    settle();
    checkOutput("reboot_pc", pc, 32'h0);
    checkOutput("reboot_instr", instr, w0);

    // Branch, JAL and JALR redirection.
    step();
    step();
    applyStimulus(0, 1, 0, 0, 32'hFFFF_FFF8, 32'd0, 0, 0, '0, 32'd0);
    settle();
    checkOutput("branch_back_pc", pc, 32'h0);
    step();
    applyStimulus(0, 0, 1, 0, 32'h0000_0010, 32'd0, 0, 0, '0, 32'd0);
    settle();
    checkOutput("jal_pc", pc, 32'h14);
    applyStimulus(0, 0, 0, 1, 32'd0, 32'h0000_0021, 0, 0, '0, 32'd0);
    settle();
    checkOutput("jalr_pc", pc, 32'h20);

    // Stall at 0xC, with a taken branch during the stall.
    applyStimulus(0, 0, 1, 0, 32'hFFFF_FFEC, 32'd0, 0, 0, '0, 32'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 0, 0, '0, 32'd0);
    applyStimulus(1, 1, 0, 0, 32'h0000_0020, 32'd0, 0, 0, '0, 32'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0, 0, 0, '0, 32'd0);
    settle();
    checkOutput("stall_pc", pc, 32'hC);
    step();
    settle();
    checkOutput("after_stall_pc", pc, 32'h10);

    // Sequential wrap past the end of the small RAM.
    applyStimulus(0, 0, 0, 1, 32'd0, 32'h0000_0038, 0, 0, '0, 32'd0);
    step();
    step();
    settle();
    checkOutput("wrap_pc", pc, 32'h40);
    checkOutput("wrap_instr", instr, w0);

    // Misaligned JAL traps; later controls are ignored until programming.
    applyStimulus(0, 0, 0, 1, 32'd0, 32'd0, 0, 0, '0, 32'd0);
    applyStimulus(0, 0, 1, 0, 32'h0000_0006, 32'd0, 0, 0, '0, 32'd0);
    settle();
    checkOutput("trap_set", 32'(trap), 32'd1);
    checkOutput("trap_valid", 32'(instr_valid), 32'd0);
    checkOutput("trap_pc", pc, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 0, 32'h0000_0008, 32'd0, 0, 0, '0, 32'd0);
    settle();
    checkOutput("trap_hold_pc", pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0, 1, 0, '0, 32'd0);
    settle();
    checkOutput("trap_cleared", 32'(trap), 32'd0);
    step();
    step();
    settle();
    checkOutput("resume_valid", 32'(instr_valid), 32'd1);
    checkOutput("resume_pc", pc, RESET_PC);

    // Random control traffic with occasional programming bursts.
    for (int k = 0; k < 500; k++) begin
      bit          st, br, j, jr, pen, pwe;
      int          s;
      logic [31:0] imm, alu;
      st  = ($urandom_range(0, 7) == 0);
      br  = ($urandom_range(0, 5) == 0);
      j   = ($urandom_range(0, 7) == 0);
      jr  = ($urandom_range(0, 9) == 0);
      s   = int'($urandom_range(0, 32)) - 16;
      imm = 32'(s * 4);
      if ($urandom_range(0, 15) == 0) imm = imm + 32'd2;
      alu = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
      pen = ($urandom_range(0, 24) == 0);
      pwe = ($urandom_range(0, 1) == 1);
      applyStimulus(st, br, j, jr, imm, alu, pen, pwe, ADDR_W'($urandom_range(0, 15)), $urandom);
    end

    // Reset in the middle of programming keeps already-written words.
    wa = $urandom;
    wb = $urandom;
    progWrite(4'd5, wa);
    progWrite(4'd6, wb);
    doReset();
    repeat (6) step();
    settle();
    checkOutput("retained_pc", pc, 32'h14);
    checkOutput("retained_word5", instr, wa);
    step();
    settle();
    checkOutput("retained_word6", instr, wb);

    settle();
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the single-cycle datapath. It owns the PC register and an internal synchronous-read instruction RAM, and it computes the next PC from branch/jump resolution fed back by the datapath. It presents the instruction that matches the current PC, together with a valid flag, to the decoder and controller. A programming port loads the RAM while the core is held off.

Parameters:
ADDR_W, 14, word-address width of the instruction RAM (depth = 2**ADDR_W words)
RESET_PC, 32'h0000_0000, PC value after reset and after leaving programming mode

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and instr this cycle
br_taken  in  1  conditional branch resolved taken (Branch & comparison result)
jal  in  1  current instr is JAL
jalr  in  1  current instr is JALR
imm32  in  32  sign-extended immediate of current instr
alu_result  in  32  rs1+imm from the ALU (JALR target before masking)
prog_en  in  1  programming mode request
prog_we  in  1  RAM write strobe (used only while prog_en)
prog_addr  in  ADDR_W  RAM word address to write
prog_data  in  32  instruction word to write
pc  out  32  PC of the instruction on instr
pc_plus4  out  32  pc+4 (link value for JAL/JALR)
instr  out  32  instruction word at pc
instr_valid  out  1  instr/pc are a live instruction; datapath commits only when high
trap  out  1  misaligned fetch target detected; sticky

Behaviour:
- FSM states: BOOT, RUN, PROG, TRAP. On reset: state=BOOT, pc=RESET_PC, instr=0, instr_valid=0, trap=0.
- RAM: 2**ADDR_W x 32, one write port, one synchronous read port (registered data, 1-cycle latency). Read index = fetch_addr[ADDR_W+1:2]. Upper PC bits are ignored, so addresses wrap modulo depth. The pc register itself wraps modulo 2**32.
- Read-ahead: fetch_addr = next_pc, combinational. On each clock edge pc<=next_pc and instr<=RAM[next_pc]. This keeps instr aligned with pc every cycle with no bubble.
- next_pc in RUN, in priority order:
  - stall: pc
  - jalr: {alu_result[31:1],1'b0}
  - jal or br_taken: pc+imm32
  - otherwise: pc+4
- All control inputs are ignored when instr_valid=0.
- BOOT: fetch_addr=RESET_PC and pc is held. After one cycle the state moves to RUN and instr_valid goes to 1. The first valid instr is RAM[RESET_PC], available 1 cycle after rst_n deasserts.
- RUN: instr_valid=1. stall holds pc and instr; the RAM re-reads pc, so the registered instr is unchanged.
- Misaligned target: a selected target with bit[1]=1 (the JALR bit0 is masked, so this cannot come from bit0) moves the state to TRAP, with trap=1 and instr_valid=0 from the next cycle. pc holds the faulting instruction's address. Only reset or prog_en leaves TRAP. trap clears on entry to PROG.
- PROG: entered from any state on the cycle after prog_en=1, including mid-stall and from TRAP. Priority is prog_en > trap > stall.
  - instr_valid=0.
  - When prog_we=1, the edge writes RAM[prog_addr]<=prog_data.
  - When prog_en falls, the state moves to BOOT with pc=RESET_PC.
- Read/write collision during BOOT after PROG: a write on the last PROG cycle to address RESET_PC must be visible on the first RUN instr. Required: read-after-write returns the new data, so the fetch reads in BOOT, not PROG.
- pc_plus4 = pc+4, combinational from the registered pc.
- Async reset mid-PROG aborts programming; RAM contents are not cleared.

Test Plan:
- Reset, RAM[0]=32'h00500093, RAM[1]=32'h00A00113, no controls → cycle 1 after rst_n rises: instr_valid=1, pc=0, instr=00500093; next cycle pc=4, instr=00A00113, pc_plus4=8.
- Program 3 words via prog_en/prog_we at addresses 0..2, drop prog_en → one BOOT cycle with instr_valid=0, then pc=0 with instr equal to the word just written at address 0.
- At pc=8 assert br_taken with imm32=-8 → next pc=0. At pc=4 assert jal with imm32=0x10 → next pc=0x14. Assert jalr with alu_result=0x21 → next pc=0x20.
- stall high 3 cycles at pc=0xC → pc and instr constant for 3 cycles; pc=0x10 on the cycle after stall drops. br_taken asserted together with stall is ignored.
- jal with imm32=6 at pc=0 → trap=1, instr_valid=0, pc=0 held indefinitely. prog_en pulse then release → trap=0, and RUN resumes from RESET_PC.
- ADDR_W=4, run sequentially past pc=0x3C → pc=0x40 fetches RAM[0]. Also assert rst_n low mid-PROG → state BOOT, pc=0, previously written words retained.
